ik_swift_readback: RTL

IK_SWIFT_READBACK -- requirements
Module: ik_swift_readback

---
 rtl/ik_swift_readback.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ik_swift_readback.sv
// Captures one delta row per cycle from the IK core after done, exposing them to the host as bytes.
// Latency: row r lands in the snapshot 2+r cycles after done; readdata is registered (1 cycle).
// Backpressure: none; done outside IDLE is dropped and flagged as a sticky overrun.
module ik_swift_readback #(
    parameter int NUM_JOINT = 6,
    parameter int DATA_W    = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    output logic [2:0]        row_select,
    input  logic [DATA_W-1:0] data,
    input  logic              chipselect,
    input  logic              read,
    input  logic [6:0]        address,
    output logic [7:0]        readdata
);

    typedef enum logic [1:0] {IDLE, CAPTURE, VALID} state_t;

    localparam logic [2:0] LAST_ROW  = 3'(NUM_JOINT - 1);
    localparam logic [6:0] LAST_ADDR = 7'(4 * NUM_JOINT + 3);

    state_t      state, state_nxt;
    logic [2:0]  cap_idx;
    logic        row_live;
    logic        valid;
    logic        overrun;
    logic        busy;
    logic [31:0] snap [NUM_JOINT];

    logic        rd_acc, last_rd, stat_rd;
    logic        start_cap, finish, ovr_set, clr_valid;
    logic [6:0]  off;
    logic [31:0] row_dat;
    logic [7:0]  rd_dat;
    logic        unused_hi;

    // The top nibble of each row is intentionally not captured.
    assign unused_hi = ^data[DATA_W-1:32];

    assign busy    = (state == CAPTURE);
    assign rd_acc  = chipselect & read;
    assign last_rd = rd_acc && (address == LAST_ADDR);
    assign stat_rd = rd_acc && (address == 7'd0);
    assign off     = address - 7'd4;

    always_comb begin
        state_nxt = state;
        start_cap = 1'b0;
        finish    = 1'b0;
        ovr_set   = 1'b0;
        clr_valid = 1'b0;
        case (state)
            IDLE: begin
                if (done) begin
                    state_nxt = CAPTURE;
                    start_cap = 1'b1;
                end
            end
            CAPTURE: begin
                ovr_set = done;
                if (row_live && cap_idx == LAST_ROW) begin
                    state_nxt = VALID;
                    finish    = 1'b1;
                end
            end
            VALID: begin
                if (last_rd) begin
                    clr_valid = 1'b1;
                    // A done racing the final read starts a fresh capture instead of overrunning.
                    if (done) begin
                        state_nxt = CAPTURE;
                        start_cap = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    ovr_set = done;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        row_dat = '0;
        for (int i = 0; i < NUM_JOINT; i++) begin
            if (off[6:2] == 5'(i)) row_dat = snap[i];
        end
        rd_dat = '0;
        if (address == 7'd0) begin
            rd_dat = {5'b0, overrun, busy, valid};
        end else if (address >= 7'd4 && address <= LAST_ADDR) begin
            case (off[1:0])
                2'd0:    rd_dat = row_dat[31:24];
                2'd1:    rd_dat = row_dat[23:16];
                2'd2:    rd_dat = row_dat[15:8];
                default: rd_dat = row_dat[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            row_select <= '0;
            cap_idx    <= '0;
            row_live   <= 1'b0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            readdata   <= '0;
            for (int i = 0; i < NUM_JOINT; i++) snap[i] <= '0;
        end else begin
            state <= state_nxt;
            if (start_cap) begin
                row_select <= '0;
                cap_idx    <= '0;
                row_live   <= 1'b0;
            end else if (state == CAPTURE) begin
                if (row_select != LAST_ROW) row_select <= row_select + 3'd1;
                // The core registers data, so the row for row_select appears one cycle later.
                row_live <= 1'b1;
                if (row_live) begin
                    snap[cap_idx] <= data[31:0];
                    if (cap_idx != LAST_ROW) cap_idx <= cap_idx + 3'd1;
                end
            end
            if (finish)         valid <= 1'b1;
            else if (clr_valid) valid <= 1'b0;
            if (ovr_set)        overrun <= 1'b1;
            else if (stat_rd)   overrun <= 1'b0;
            if (rd_acc) readdata <= rd_dat;
        end
    end

endmodule
